// File: rtl/kbd_pkg.sv
// rtl/kbd_pkg.sv - scancode constants, event entry layout and ASCII translation
//
// Purpose : shared definitions for the key event queue.
// Contents: set-2 scancode constants, 19-bit event entry struct,
//           repeat FSM state type, scan_to_ascii(code, shift).
package kbd_pkg;

  localparam int ENTRY_W = 19;

  localparam logic [8:0] SC_LSHIFT = 9'h012, SC_RSHIFT = 9'h059;
  localparam logic [8:0] SC_ENTER  = 9'h05A, SC_SPACE  = 9'h029, SC_BKSP = 9'h066;

  localparam logic [7:0] SC_A = 8'h1C, SC_B = 8'h32, SC_C = 8'h21, SC_D = 8'h23;
  localparam logic [7:0] SC_E = 8'h24, SC_F = 8'h2B, SC_G = 8'h34, SC_H = 8'h33;
  localparam logic [7:0] SC_I = 8'h43, SC_J = 8'h3B, SC_K = 8'h42, SC_L = 8'h4B;
  localparam logic [7:0] SC_M = 8'h3A, SC_N = 8'h31, SC_O = 8'h44, SC_P = 8'h4D;
  localparam logic [7:0] SC_Q = 8'h15, SC_R = 8'h2D, SC_S = 8'h1B, SC_T = 8'h2C;
  localparam logic [7:0] SC_U = 8'h3C, SC_V = 8'h2A, SC_W = 8'h1D, SC_X = 8'h22;
  localparam logic [7:0] SC_Y = 8'h35, SC_Z = 8'h1A;

  localparam logic [7:0] SC_0 = 8'h45, SC_1 = 8'h16, SC_2 = 8'h1E, SC_3 = 8'h26;
  localparam logic [7:0] SC_4 = 8'h25, SC_5 = 8'h2E, SC_6 = 8'h36, SC_7 = 8'h3D;
  localparam logic [7:0] SC_8 = 8'h3E, SC_9 = 8'h46;

  typedef struct packed {
    logic       press;
    logic       rpt;
    logic [8:0] code;
    logic [7:0] ascii;
  } kbd_event_t;

  typedef enum logic [1:0] {RPT_IDLE, RPT_DELAY, RPT_REPEAT} rpt_state_t;

  function automatic logic [7:0] scan_to_ascii(input logic [8:0] code, input logic shift);
    logic [7:0] a;
    a = 8'h00;
    if (!code[8]) begin
      case (code[7:0])
        SC_A: a = 8'h61;  SC_B: a = 8'h62;  SC_C: a = 8'h63;  SC_D: a = 8'h64;
        SC_E: a = 8'h65;  SC_F: a = 8'h66;  SC_G: a = 8'h67;  SC_H: a = 8'h68;
        SC_I: a = 8'h69;  SC_J: a = 8'h6A;  SC_K: a = 8'h6B;  SC_L: a = 8'h6C;
        SC_M: a = 8'h6D;  SC_N: a = 8'h6E;  SC_O: a = 8'h6F;  SC_P: a = 8'h70;
        SC_Q: a = 8'h71;  SC_R: a = 8'h72;  SC_S: a = 8'h73;  SC_T: a = 8'h74;
        SC_U: a = 8'h75;  SC_V: a = 8'h76;  SC_W: a = 8'h77;  SC_X: a = 8'h78;
        SC_Y: a = 8'h79;  SC_Z: a = 8'h7A;
        SC_0: a = 8'h30;  SC_1: a = 8'h31;  SC_2: a = 8'h32;  SC_3: a = 8'h33;
        SC_4: a = 8'h34;  SC_5: a = 8'h35;  SC_6: a = 8'h36;  SC_7: a = 8'h37;
        SC_8: a = 8'h38;  SC_9: a = 8'h39;
        SC_SPACE[7:0]: a = 8'h20;
        SC_ENTER[7:0]: a = 8'h0D;
        SC_BKSP[7:0]:  a = 8'h08;
        default: a = 8'h00;
      endcase
    end
    // Only letters react to shift; digits and controls keep their code.
    if (shift && a >= 8'h61 && a <= 8'h7A) a = a - 8'h20;
    return a;
  endfunction

endpackage

// File: rtl/key_event_queue_if.sv
// rtl/key_event_queue_if.sv - decoder/consumer bundle for the key event queue
//
// Purpose : groups decoder inputs, consumer controls and queue head/status.
// Signals : key_down, last_change, key_valid, rd_en, ovf_clr (towards queue);
//           ev_valid, ev_press, ev_repeat, ev_code, ev_ascii, empty, full,
//           count, overflow (from queue).
// Modports: master = decoder/consumer side, slave = key_event_queue.
interface key_event_queue_if #(parameter int DEPTH = 16);
  logic [511:0]           key_down;
  logic [8:0]             last_change;
  logic                   key_valid;
  logic                   rd_en;
  logic                   ovf_clr;
  logic                   ev_valid;
  logic                   ev_press;
  logic                   ev_repeat;
  logic [8:0]             ev_code;
  logic [7:0]             ev_ascii;
  logic                   empty;
  logic                   full;
  logic [$clog2(DEPTH):0] count;
  logic                   overflow;

  modport master (
    output key_down, last_change, key_valid, rd_en, ovf_clr,
    input  ev_valid, ev_press, ev_repeat, ev_code, ev_ascii, empty, full, count, overflow
  );

  modport slave (
    input  key_down, last_change, key_valid, rd_en, ovf_clr,
    output ev_valid, ev_press, ev_repeat, ev_code, ev_ascii, empty, full, count, overflow
  );
endinterface

// File: rtl/kbd_event_fifo.sv
// rtl/kbd_event_fifo.sv - first-word-fall-through synchronous FIFO
//
// Purpose : generic FWFT FIFO; head word is visible whenever not empty.
// Ports   : clk, rst (async high); wr_en_i/wr_data_i write side;
//           rd_en_i pop, rd_data_o head (zero when empty);
//           empty_o, full_o, count_o status; drop_o = write refused this cycle.
module kbd_event_fifo #(
  parameter int WIDTH = 19,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_en_i,
  output logic [WIDTH-1:0]         rd_data_o,
  output logic                     empty_o,
  output logic                     full_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     drop_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_wr, do_rd;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == CW'(DEPTH));
  // A read frees a slot in the same cycle, so a full FIFO still accepts.
  assign do_rd   = rd_en_i && !empty_o;
  assign do_wr   = wr_en_i && (!full_o || do_rd);
  assign drop_o  = wr_en_i && !do_wr;

  assign rd_data_o = empty_o ? '0 : mem_q[rd_ptr_q];
  assign count_o   = count_q;

  always_comb begin
    wr_ptr_d = do_wr ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = do_rd ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_wr) - CW'(do_rd);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end
endmodule

// File: rtl/key_event_queue.sv
// rtl/key_event_queue.sv - turns key transitions into queued press/release events
//
// Purpose : captures decoder transitions, translates to ASCII, queues them in a
//           FWFT FIFO, flags lost events; optional typematic repeat generator.
// Ports   : clk, rst (async high); bus (key_event_queue_if.slave) carrying
//           decoder inputs, rd_en/ovf_clr and head/status outputs.
// Macro   : KEY_REPEAT_EN compiles in the IDLE/DELAY/REPEAT auto-repeat FSM.
module key_event_queue
  import kbd_pkg::*;
#(
  parameter int DEPTH         = 16,
  parameter int STORE_RELEASE = 1,
  parameter int REPEAT_DELAY  = 50_000_000,
  parameter int REPEAT_PERIOD = 10_000_000
) (
  input logic               clk,
  input logic               rst,
  key_event_queue_if.slave  bus
);
  logic       key_press, shift, key_wr;
  logic [7:0] key_ascii;
  kbd_event_t key_entry, wr_entry, head;
  logic       fifo_wr, fifo_empty, fifo_drop;
  logic       overflow_q, overflow_d;

  assign key_press = bus.key_down[bus.last_change];
  assign shift     = bus.key_down[SC_LSHIFT] | bus.key_down[SC_RSHIFT];
  assign key_ascii = scan_to_ascii(bus.last_change, shift);
  assign key_wr    = bus.key_valid && (key_press || (STORE_RELEASE != 0));
  assign key_entry = '{press: key_press, rpt: 1'b0, code: bus.last_change, ascii: key_ascii};

`ifdef KEY_REPEAT_EN
  rpt_state_t state_q;
  logic [31:0] timer_q;
  logic [8:0]  code_q;
  logic        rep_fire, rep_wr;
  kbd_event_t  rep_entry;

  assign rep_fire  = (state_q != RPT_IDLE) && (timer_q == 32'd1);
  // A coincident decoder event takes the write port; the repeat is skipped.
  assign rep_wr    = rep_fire && !bus.key_valid;
  assign rep_entry = '{press: 1'b1, rpt: 1'b1, code: code_q, ascii: scan_to_ascii(code_q, shift)};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RPT_IDLE;
      timer_q <= '0;
      code_q  <= '0;
    end else begin
      if (rep_fire) begin
        state_q <= RPT_REPEAT;
        timer_q <= 32'(REPEAT_PERIOD);
      end else if (state_q != RPT_IDLE) begin
        timer_q <= timer_q - 32'd1;
      end
      // Decoder events override the timer path: new mapped press re-latches,
      // release of the latched key stops, everything else leaves it running.
      if (bus.key_valid) begin
        if (key_press && key_ascii != 8'h00) begin
          code_q  <= bus.last_change;
          state_q <= RPT_DELAY;
          timer_q <= 32'(REPEAT_DELAY);
        end else if (!key_press && state_q != RPT_IDLE && bus.last_change == code_q) begin
          state_q <= RPT_IDLE;
        end
      end
    end
  end

  assign fifo_wr       = key_wr || rep_wr;
  assign wr_entry      = key_wr ? key_entry : rep_entry;
  assign bus.ev_repeat = head.rpt;
`else
  logic unused_repeat_cfg;
  assign unused_repeat_cfg = ^{32'(REPEAT_DELAY), 32'(REPEAT_PERIOD), head.rpt};
  assign fifo_wr       = key_wr;
  assign wr_entry      = key_entry;
  assign bus.ev_repeat = 1'b0;
`endif

  kbd_event_fifo #(.WIDTH(ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .wr_en_i   (fifo_wr),
    .wr_data_i (wr_entry),
    .rd_en_i   (bus.rd_en),
    .rd_data_o (head),
    .empty_o   (fifo_empty),
    .full_o    (bus.full),
    .count_o   (bus.count),
    .drop_o    (fifo_drop)
  );

  // Setting beats clearing so a loss in the clear cycle is never hidden.
  assign overflow_d = fifo_drop ? 1'b1 : (bus.ovf_clr ? 1'b0 : overflow_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) overflow_q <= 1'b0;
    else     overflow_q <= overflow_d;
  end

  assign bus.empty    = fifo_empty;
  assign bus.ev_valid = !fifo_empty;
  assign bus.ev_press = head.press;
  assign bus.ev_code  = head.code;
  assign bus.ev_ascii = head.ascii;
  assign bus.overflow = overflow_q;
endmodule

// File: tb/tb_key_event_queue.sv
// tb/tb_key_event_queue.sv - directed self-checking bench for key_event_queue
module tb_key_event_queue;
  logic clk = 1'b0;
  logic rst;
  logic [511:0] kd;
  logic [8:0] lc;
  logic kv, rd0, rd1, oc;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  key_event_queue_if #(.DEPTH(16)) if0 ();
  key_event_queue_if #(.DEPTH(16)) if1 ();

  assign if0.key_down = kd;  assign if0.last_change = lc;  assign if0.key_valid = kv;
  assign if0.rd_en = rd0;    assign if0.ovf_clr = oc;
  assign if1.key_down = kd;  assign if1.last_change = lc;  assign if1.key_valid = kv;
  assign if1.rd_en = rd1;    assign if1.ovf_clr = oc;

  key_event_queue #(.DEPTH(16), .STORE_RELEASE(1), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) u0 (
    .clk(clk), .rst(rst), .bus(if0));
  key_event_queue #(.DEPTH(16), .STORE_RELEASE(0), .REPEAT_DELAY(20), .REPEAT_PERIOD(5)) u1 (
    .clk(clk), .rst(rst), .bus(if1));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic kev(input logic [8:0] code, input logic dn);
    kd[code] = dn;
    lc = code;
    kv = 1'b1;
    step();
    kv = 1'b0;
  endtask

  task automatic pop0();
    rd0 = 1'b1;
    step();
    rd0 = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    kd = '0; lc = '0; kv = 0; rd0 = 0; rd1 = 0; oc = 0; rst = 1'b1;
    step(); step();
    rst = 1'b0;

    chk("rst_empty", if0.empty, 1'b1);
    chk("rst_count", if0.count, 5'd0);
    chk("rst_full", if0.full, 1'b0);
    chk("rst_valid", if0.ev_valid, 1'b0);
    chk("rst_head", {if0.ev_press, if0.ev_repeat, if0.ev_code, if0.ev_ascii}, 19'h0);
    chk("rst_ovf", if0.overflow, 1'b0);

    kev(9'h01C, 1'b1);
    chk("a_valid", if0.ev_valid, 1'b1);
    chk("a_head", {if0.ev_press, if0.ev_repeat, if0.ev_code, if0.ev_ascii}, {1'b1, 1'b0, 9'h01C, 8'h61});
    kev(9'h01C, 1'b0);
    chk("a_rel_count", if0.count, 5'd2);
    chk("a_head_stable", if0.ev_press, 1'b1);
    pop0();
    chk("a_rel_head", {if0.ev_press, if0.ev_code, if0.ev_ascii}, {1'b0, 9'h01C, 8'h61});
    chk("a_rel_count1", if0.count, 5'd1);
    pop0();
    chk("a_drained", if0.empty, 1'b1);

    kev(9'h012, 1'b1);
    chk("lshift_ascii", {if0.ev_code, if0.ev_ascii}, {9'h012, 8'h00});
    pop0();
    kev(9'h01C, 1'b1);
    chk("shift_A", if0.ev_ascii, 8'h41);
    pop0();
    kev(9'h16B, 1'b1);
    chk("ext_code", {if0.ev_code, if0.ev_ascii}, {9'h16B, 8'h00});
    pop0();
    kev(9'h012, 1'b0);
    kev(9'h01C, 1'b0);
    kev(9'h16B, 1'b0);
    chk("three_rel", if0.count, 5'd3);
    kev(9'h05A, 1'b1);
    kev(9'h05A, 1'b0);
    chk("five_queued", if0.count, 5'd5);

    do_reset();
    chk("midrst_empty", if0.empty, 1'b1);
    chk("midrst_count", if0.count, 5'd0);
    chk("midrst_valid", if0.ev_valid, 1'b0);

    pop0();
    chk("rd_empty_count", if0.count, 5'd0);
    chk("rd_empty_empty", if0.empty, 1'b1);

    rd0 = 1'b1;
    kev(9'h066, 1'b1);
    rd0 = 1'b0;
    chk("wr_rd_empty_count", if0.count, 5'd1);
    chk("bksp_ascii", if0.ev_ascii, 8'h08);
    kev(9'h066, 1'b0);
    do_reset();

    for (int i = 0; i < 16; i++) kev(9'h16B, 1'b1);
    chk("fill_count", if0.count, 5'd16);
    chk("fill_full", if0.full, 1'b1);
    chk("fill_ovf0", if0.overflow, 1'b0);
    kev(9'h16B, 1'b1);
    chk("ovf_count", if0.count, 5'd16);
    chk("ovf_set", if0.overflow, 1'b1);
    oc = 1'b1; step(); oc = 1'b0;
    chk("ovf_clr", if0.overflow, 1'b0);
    rd0 = 1'b1;
    kev(9'h16B, 1'b1);
    rd0 = 1'b0;
    chk("full_wr_rd_count", if0.count, 5'd16);
    chk("full_wr_rd_ovf", if0.overflow, 1'b0);
    chk("full_wr_rd_full", if0.full, 1'b1);
    oc = 1'b1;
    kev(9'h16B, 1'b1);
    oc = 1'b0;
    chk("set_beats_clr", if0.overflow, 1'b1);
    oc = 1'b1; step(); oc = 1'b0;
    chk("ovf_clr2", if0.overflow, 1'b0);
    kd[9'h16B] = 1'b0;

    do_reset();
    kev(9'h045, 1'b1);
    kev(9'h045, 1'b0);
    chk("norel_count", if1.count, 5'd1);
    chk("norel_head", {if1.ev_press, if1.ev_code, if1.ev_ascii}, {1'b1, 9'h045, 8'h30});
    chk("rel_count", if0.count, 5'd2);

`ifdef KEY_REPEAT_EN
    do_reset();
    kev(9'h029, 1'b1);
    repeat (19) step();
    chk("rpt_before", if0.count, 5'd1);
    step();
    chk("rpt_first", if0.count, 5'd2);
    repeat (4) step();
    chk("rpt_gap", if0.count, 5'd2);
    step();
    chk("rpt_second", if0.count, 5'd3);
    pop0();
    chk("rpt_head", {if0.ev_press, if0.ev_repeat, if0.ev_code, if0.ev_ascii}, {1'b1, 1'b1, 9'h029, 8'h20});
    kev(9'h029, 1'b0);
    chk("rpt_release", if0.count, 5'd3);
    repeat (30) step();
    chk("rpt_stopped", if0.count, 5'd3);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/key_event_queue.md
# key_event_queue

Consumes the key-decoder outputs (`key_down`, `last_change`, `key_valid`) and turns each key transition into a queued event for the game/UI logic. Each event carries press/release, the 9-bit extended scancode and a translated ASCII byte. Events sit in a first-word-fall-through FIFO that the consumer drains with a read strobe; overflow is flagged, never silently hidden. An optional typematic generator injects auto-repeat press events.

## Interface
- `DEPTH`, 16: FIFO entries, power of two, 4..64.
- `STORE_RELEASE`, 1: 1 = queue release events; 0 = drop them.
- `REPEAT_DELAY`, 50_000_000: cycles a key is held before the first repeat. Used only with the repeat feature.
- `REPEAT_PERIOD`, 10_000_000: cycles between subsequent repeats. Used only with the repeat feature.
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous, active-high reset.
- `key_down`  in  512  decoder key-state vector, one bit per extended scancode.
- `last_change`  in  9  scancode of the most recent transition, {extend, code[7:0]}.
- `key_valid`  in  1  one-cycle strobe: a transition occurred and `key_down` is already updated.
- `rd_en`  in  1  consumer pops the head entry.
- `ovf_clr`  in  1  clears `overflow`.
- `ev_valid`  out  1  head entry present; equals `!empty`.
- `ev_press`  out  1  head entry is a press (1) or a release (0).
- `ev_repeat`  out  1  head entry came from the auto-repeat generator.
- `ev_code`  out  9  head entry scancode.
- `ev_ascii`  out  8  head entry ASCII byte; 8'h00 if the key has no mapping.
- `empty`  out  1  FIFO empty.
- `full`  out  1  FIFO full.
- `count`  out  $clog2(DEPTH)+1  occupancy.
- `overflow`  out  1  sticky: at least one event was lost.

## Operation
- Capture: on a `key_valid` cycle, `press = key_down[last_change]`.
- If `press == 0` and `STORE_RELEASE == 0`, nothing is written. Otherwise one entry {press, repeat=0, code, ascii} is written.
- ASCII translation uses `shift = key_down[9'h012] | key_down[9'h059]`. Sampling `key_down` in the same cycle means the shift keys themselves translate to 8'h00.
- Mapped keys:
  - letters: lowercase by default, uppercase with shift (A=1C … Z=1A, set-2 codes);
  - digits 0-9: shift has no effect;
  - space 29 → 8'h20; enter 5A → 8'h0D; backspace 66 → 8'h08;
  - any extended code (bit 8 set) → 8'h00.
- FIFO rules:
  - Write while full with no read: entry dropped, `overflow` set.
  - Write and read in the same cycle while full: both succeed, `count` unchanged.
  - `rd_en` while empty: ignored.
  - Write and read in the same cycle while empty: read ignored, write accepted.
- `overflow` clears only on `ovf_clr` or `rst`. If a set condition and `ovf_clr` occur in the same cycle, set wins.
- Pointers wrap modulo DEPTH.

## Timing
- Reset: FIFO empty, `count = 0`, `empty = 1`, `full = 0`, `ev_valid = 0`, all `ev_*` = 0, `overflow = 0`, repeat FSM in IDLE.
- Latency: `key_valid` high in cycle N → entry is at the head in cycle N+1 if the FIFO was empty.
- `rd_en` in cycle N → next entry (or empty) is visible in cycle N+1.
- Head outputs are registered/FWFT. They are stable while `ev_valid && !rd_en`.
- Reset mid-operation discards all queued entries and repeat state immediately.

## Configuration
- `KEY_REPEAT_EN` defined: repeat FSM is compiled in with states IDLE, DELAY and REPEAT.
  - A queued or filtered press of a key with non-zero ASCII latches that code and enters DELAY with the timer at REPEAT_DELAY.
  - When the timer expires, a press entry with repeat=1 is written (ASCII recomputed with the current shift), and the FSM enters or stays in REPEAT with the timer at REPEAT_PERIOD.
  - Release of the latched key → IDLE. Any new press re-latches and restarts DELAY. Releases of other keys are ignored.
  - If expiry coincides with `key_valid`, the `key_valid` event is written, the repeat event is dropped (not counted as overflow), and the timer reloads.
- `KEY_REPEAT_EN` undefined: no FSM or timer; `ev_repeat` is tied to 0; REPEAT_* parameters are unused.

## Structure
- Package `kbd_pkg`:
  - scancode constants (LSHIFT 9'h012, RSHIFT 9'h059, ENTER, SPACE, BKSP, letters, digits);
  - entry-width constant (19);
  - `scan_to_ascii(code, shift)` function.
- Sub-module `kbd_event_fifo`: generic FWFT synchronous FIFO (WIDTH, DEPTH) providing count, full, empty and a drop indication. The top level holds the capture, translation, repeat and overflow logic.

## Test plan
- Press 1C, no shift → head {press=1, code=01C, ascii=8'h61}. Then release → second entry {0, 01C, 61}, `count = 2`.
- Hold 012, press 1C → ascii 8'h41. Press E0-prefixed 6B (code 16B) → ascii 8'h00.
- Set `STORE_RELEASE = 0`, then press and release 45 → exactly one entry {1, 045, 8'h30}.
- Fill 16 entries, then one more `key_valid` → `full = 1`, `overflow = 1`, `count = 16`. Repeat with `rd_en` asserted in the same cycle → no overflow. `ovf_clr` → `overflow = 0`.
- `rd_en` while empty → `count` stays 0. `rst` with 5 entries queued → `empty = 1` next cycle.
- `KEY_REPEAT_EN` with REPEAT_DELAY=20, REPEAT_PERIOD=5: hold 29 → repeat entries (ascii 8'h20, `ev_repeat = 1`) 20 cycles after the press, then every 5 cycles. Release 29 → repeats stop.
